// File: rtl/fetch_pkg.sv
// Shared types and default configuration for the fetch/PC unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_pkg;

    // Sequencer states: one boot cycle, request handshake, response wait, execute.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        EXEC = 2'd3
    } fetch_state_t;

    // Default configuration values, used as the unit's parameter defaults.
    localparam int                FETCH_XLEN         = 32;
    localparam logic [31:0]       FETCH_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0]       FETCH_TRAP_VECTOR  = 32'h0000_0100;
    localparam int                FETCH_CNT_W        = 32;

    // Byte offset between sequential instructions.
    localparam int                INSTR_BYTES        = 4;

endpackage

// File: rtl/fetch_pc_unit_instret_counter.sv
// Retired-instruction counter: increments by one on each inc cycle, wraps at 2^CNT_W.
// Latency: count reflects an increment on the cycle after inc.
// Backpressure: none; inc is accepted every cycle.
module instret_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Free-running wrap-around count of retire events.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding fetch sequencer (BOOT -> REQ -> WAIT -> EXEC).
// Latency: min 3 cycles per instruction (REQ, WAIT, EXEC); BOOT adds one cycle after reset.
// Backpressure: holds imem request/address until imem_req_ready; stall holds EXEC. Build option: MISALIGN_TRAP_EN.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN         = FETCH_XLEN,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(FETCH_RESET_VECTOR),
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(FETCH_TRAP_VECTOR),
    parameter int               CNT_W        = FETCH_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_src,
    input  logic [XLEN-1:0]  pc_target,
    input  logic             stall,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    fetch_state_t    state_q;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     instr_q;
    logic            retire;
    logic            rsp_take;
    logic            take_trap;

    // Sequential successor; wraps modulo 2^XLEN with no fault.
    assign seq_pc   = pc_q + XLEN'(INSTR_BYTES);

    // Retire happens on the EXEC edge that is not stalled.
    assign retire   = (state_q == EXEC) && !stall;

    // Responses are only meaningful while waiting; BOOT and REQ drop them.
    assign rsp_take = (state_q == WAIT) && imem_rsp_valid;

`ifdef MISALIGN_TRAP_EN
    logic trap_q;

    // A taken branch to a non-word-aligned target diverts to the trap vector.
    assign take_trap   = pc_src && (pc_target[1:0] != 2'b00);
    assign redirect_pc = take_trap ? TRAP_VECTOR : pc_target;

    // Trap is a single-cycle pulse in the cycle following the retiring edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= retire && take_trap;
        end
    end

    assign trap = trap_q;
`else
    // Without trap support the target is simply word-aligned by masking.
    assign take_trap   = 1'b0;
    assign redirect_pc = pc_target & ~XLEN'(3);
    assign trap        = 1'b0;
`endif

    // Next-state logic for the fetch sequencer.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            BOOT:    state_nxt = REQ;
            REQ:     if (imem_req_ready) state_nxt = WAIT;
            WAIT:    if (imem_rsp_valid) state_nxt = EXEC;
            EXEC:    if (!stall)         state_nxt = REQ;
            default: state_nxt = BOOT;
        endcase
    end

    // Next PC: only changes on retire; pc_src/pc_target are ignored elsewhere.
    always_comb begin
        pc_nxt = pc_q;
        if (retire) begin
            pc_nxt = pc_src ? redirect_pc : seq_pc;
        end
    end

    // State register; reset always re-enters BOOT so an in-flight response is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_nxt;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_nxt;
        end
    end

    // Instruction register: captured once per fetch, held through stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= 32'h0;
        end else if (rsp_take) begin
            instr_q <= imem_rsp_data;
        end
    end

    instret_counter #(
        .CNT_W (CNT_W)
    ) u_instret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .count (instret)
    );

    // The request address is the registered PC, so it is stable while valid && !ready.
    assign imem_req_valid = (state_q == REQ);
    assign imem_addr      = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = (state_q == EXEC);
    assign pc             = pc_q;
    assign pc_plus4       = seq_pc;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        trap;
    logic [31:0] instret;

    int checks;
    int failures;
    logic [31:0] exp_ret;

    fetch_pc_unit dut (
        .clk            (clk),
        .rst            (rst),
        .pc_src         (pc_src),
        .pc_target      (pc_target),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .trap           (trap),
        .instret        (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // From REQ: accept the request, return data next cycle; ends in EXEC.
    task automatic fetch(input logic [31:0] d);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("wait_req_vld", {31'b0, imem_req_valid}, 32'd0);
        check("wait_ivld", {31'b0, instr_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = d;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        check("exec_ivld", {31'b0, instr_valid}, 32'd1);
        check("exec_instr", instr, d);
    endtask

    // In EXEC: retire with the given redirect choice.
    task automatic retire_with(input logic src, input logic [31:0] tgt);
        pc_src    = src;
        pc_target = tgt;
        stall     = 1'b0;
        step();
        pc_src    = 1'b0;
        pc_target = 32'h0;
        exp_ret   = exp_ret + 32'd1;
        check("instret", instret, exp_ret);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        exp_ret        = 32'd0;
        rst            = 1'b1;
        pc_src         = 1'b0;
        pc_target      = 32'h0;
        stall          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        step();
        step();

        // Reset state.
        check("rst_req_vld", {31'b0, imem_req_valid}, 32'd0);
        check("rst_ivld", {31'b0, instr_valid}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_trap", {31'b0, trap}, 32'd0);
        check("rst_instret", instret, 32'd0);

        // BOOT lasts one cycle; a response here is dropped.
        rst            = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0001;
        step();
        imem_rsp_valid = 1'b0;
        check("boot_ivld", {31'b0, instr_valid}, 32'd0);

        // Test 1: sequential fetch 0x0, 0x4, 0x8.
        for (int i = 0; i < 3; i++) begin
            check("t1_req_vld", {31'b0, imem_req_valid}, 32'd1);
            check("t1_addr", imem_addr, 32'(i * 4));
            fetch(32'h0000_0013 + 32'(i));
            check("t1_pc", pc, 32'(i * 4));
            retire_with(1'b0, 32'h0);
        end
        check("t1_instret3", instret, 32'd3);
        check("t1_next", imem_addr, 32'h0000_000C);

        // Test 2: reach 0x10, branch to 0x40, come back, then fall through to 0x14.
        fetch(32'h1111_0001);
        retire_with(1'b0, 32'h0);
        check("t2_at10", imem_addr, 32'h0000_0010);
        fetch(32'h1111_0002);
        check("t2_plus4", pc_plus4, 32'h0000_0014);
        retire_with(1'b1, 32'h0000_0040);
        check("t2_taken", imem_addr, 32'h0000_0040);
        check("t2_req_vld", {31'b0, imem_req_valid}, 32'd1);
        fetch(32'h1111_0003);
        retire_with(1'b1, 32'h0000_0010);
        fetch(32'h1111_0004);
        retire_with(1'b0, 32'h0000_0040);
        check("t2_seq", imem_addr, 32'h0000_0014);

        // Test 3: stall five cycles at 0x10 with pc_src toggling.
        fetch(32'h2222_0001);
        retire_with(1'b1, 32'h0000_0010);
        fetch(32'h3333_0001);
        for (int i = 0; i < 5; i++) begin
            stall     = 1'b1;
            pc_src    = i[0];
            pc_target = 32'h0000_0080;
            step();
            check("t3_pc", pc, 32'h0000_0010);
            check("t3_instr", instr, 32'h3333_0001);
            check("t3_ivld", {31'b0, instr_valid}, 32'd1);
            check("t3_instret", instret, exp_ret);
        end
        retire_with(1'b0, 32'h0000_0080);
        check("t3_release", imem_addr, 32'h0000_0014);

        // Test 4: request held four cycles; responses in REQ are ignored.
        for (int i = 0; i < 4; i++) begin
            imem_req_ready = 1'b0;
            imem_rsp_valid = i[0];
            imem_rsp_data  = 32'hBAD0_0002;
            step();
            check("t4_req_vld", {31'b0, imem_req_valid}, 32'd1);
            check("t4_addr", imem_addr, 32'h0000_0014);
            check("t4_ivld", {31'b0, instr_valid}, 32'd0);
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;

        // Test 5: misaligned taken target.
        fetch(32'h4444_0001);
        retire_with(1'b1, 32'h0000_0042);
`ifdef MISALIGN_TRAP_EN
        check("t5_trap", {31'b0, trap}, 32'd1);
        check("t5_pc", pc, 32'h0000_0100);
`else
        check("t5_trap", {31'b0, trap}, 32'd0);
        check("t5_pc", pc, 32'h0000_0040);
`endif
        step();
        check("t5_trap_end", {31'b0, trap}, 32'd0);

        // Test 6: reset in WAIT, response arrives during BOOT.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("t6_in_wait", {31'b0, imem_req_valid}, 32'd0);
        rst = 1'b1;
        step();
        rst            = 1'b0;
        exp_ret        = 32'd0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0003;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        check("t6_ivld", {31'b0, instr_valid}, 32'd0);
        check("t6_instr", instr, 32'h0);
        check("t6_req_vld", {31'b0, imem_req_valid}, 32'd1);
        check("t6_addr", imem_addr, 32'h0);
        check("t6_instret", instret, 32'd0);

        // PC wrap: 0xFFFF_FFFC + 4 -> 0.
        fetch(32'h5555_0001);
        retire_with(1'b1, 32'hFFFF_FFFC);
        check("wrap_hi", imem_addr, 32'hFFFF_FFFC);
        fetch(32'h5555_0002);
        check("wrap_plus4", pc_plus4, 32'h0);
        retire_with(1'b0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
